hamming_rx_ctrl: RTL and testbench



---
 rtl/hamming_pkg.sv | 37 +++
 rtl/hamming12_syndrome.sv | 46 ++++
 rtl/hamming_rx_ctrl.sv | 179 +++++++++++++++++
 tb/tb_hamming_rx_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// hamming_pkg: shared constants and types for the Hamming(12,8) receive path.
//   CW_W / DATA_W : codeword and payload widths
//   CHK_POS*      : bit positions of the four check bits inside the codeword
//   err_t         : per-byte status reported to the sink
//   state_t       : receive controller FSM states
//   extract_data  : pulls the eight payload bits out of a codeword
package hamming_pkg;

   localparam int unsigned CW_W   = 12;
   localparam int unsigned DATA_W = 8;

   // Check bits sit at the power-of-two Hamming positions 1, 2, 4, 8 (1-based).
   localparam int unsigned CHK_POS0 = 0;
   localparam int unsigned CHK_POS1 = 1;
   localparam int unsigned CHK_POS2 = 3;
   localparam int unsigned CHK_POS3 = 7;

   // Largest syndrome that names a real codeword bit; above this is uncorrectable.
   localparam logic [3:0] SYN_MAX_CORR = 4'd12;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'b00,
      ERR_CORR   = 2'b01,
      ERR_UNCORR = 2'b10
   } err_t;

   typedef enum logic [1:0] {
      S_COLLECT = 2'b00,
      S_DECODE  = 2'b01,
      S_PUSH    = 2'b10
   } state_t;

   function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
      return {cw[11], cw[10], cw[9], cw[8], cw[6], cw[5], cw[4], cw[2]};
   endfunction

endpackage

// File: rtl/hamming12_syndrome.sv
// hamming12_syndrome: combinational single-error corrector for one 12-bit codeword.
//   cw_i       : received codeword, cw_i[0] is the first bit on the wire
//   syndrome_o : 4-bit syndrome; 1..12 names the 1-based position of a flipped bit
//   data_o     : payload extracted after correction
//   err_o      : ERR_NONE / ERR_CORR / ERR_UNCORR
module hamming12_syndrome
   import hamming_pkg::*;
(
   input  logic [CW_W-1:0]   cw_i,
   output logic [3:0]        syndrome_o,
   output logic [DATA_W-1:0] data_o,
   output err_t              err_o
);

   logic [3:0]      syn;
   logic [CW_W-1:0] cw_fix;

   always_comb begin
      syn[0] = cw_i[0] ^ cw_i[2] ^ cw_i[4] ^ cw_i[6] ^ cw_i[8] ^ cw_i[10];
      syn[1] = cw_i[1] ^ cw_i[2] ^ cw_i[5] ^ cw_i[6] ^ cw_i[9] ^ cw_i[10];
      syn[2] = cw_i[3] ^ cw_i[4] ^ cw_i[5] ^ cw_i[6] ^ cw_i[11];
      syn[3] = cw_i[7] ^ cw_i[8] ^ cw_i[9] ^ cw_i[10] ^ cw_i[11];
   end

   always_comb begin
      cw_fix = cw_i;
      err_o  = ERR_NONE;
      if (syn == 4'd0) begin
         err_o = ERR_NONE;
      end else if (syn <= SYN_MAX_CORR) begin
         err_o = ERR_CORR;
         // Syndrome s points at cw[s-1].
         for (int i = 0; i < CW_W; i++) begin
            if (syn == 4'(i + 1)) begin
               cw_fix[i] = ~cw_i[i];
            end
         end
      end else begin
         err_o = ERR_UNCORR;
      end
   end

   assign syndrome_o = syn;
   assign data_o     = extract_data(cw_fix);

endmodule

// File: rtl/hamming_rx_ctrl.sv
// hamming_rx_ctrl: assembles demodulated bits into Hamming(12,8) codewords, corrects
// single errors and hands decoded bytes to a valid/ready sink.
//   clk, rst               : clock, synchronous active-high reset
//   bit_in, bit_valid      : serial hard-decision bits, LSB of the codeword first
//   out_data, out_err      : decoded byte and its status (00 clean, 01 corr, 10 uncorr)
//   out_valid, out_ready   : single-entry output buffer handshake
//   corr_cnt, uncorr_cnt   : saturating counts of corrected / uncorrectable codewords
//   drop_cnt               : saturating count of bytes lost to a full output buffer
//   timeout_cnt            : saturating count of partial codewords aborted by a bit gap
//   busy                   : a codeword is partially collected or being decoded
module hamming_rx_ctrl
   import hamming_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_in,
   input  logic              bit_valid,
   output logic [7:0]        out_data,
   output logic [1:0]        out_err,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic [CNT_W-1:0]  timeout_cnt,
   output logic              busy
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

   state_t              state_q, state_d;
   logic [3:0]          bit_cnt_q, bit_cnt_d;
   logic [CW_W-1:0]     sr_q, sr_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [3:0]          syn_q, syn_d;
   logic [DATA_W-1:0]   dec_data_q, dec_data_d;
   err_t                dec_err_q, dec_err_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   err_t                out_err_q, out_err_d;
   logic                out_valid_q, out_valid_d;
   logic [CNT_W-1:0]    corr_q, corr_d;
   logic [CNT_W-1:0]    uncorr_q, uncorr_d;
   logic [CNT_W-1:0]    drop_q, drop_d;
   logic [CNT_W-1:0]    tout_q, tout_d;

   logic [3:0]          syn_comb;
   logic [DATA_W-1:0]   data_comb;
   err_t                err_comb;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // During S_DECODE sr_q still holds the complete codeword; a bit arriving in
   // that cycle only shifts in at the closing edge.
   hamming12_syndrome u_syndrome (
      .cw_i       (sr_q),
      .syndrome_o (syn_comb),
      .data_o     (data_comb),
      .err_o      (err_comb)
   );

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      sr_d        = sr_q;
      tmr_d       = tmr_q;
      syn_d       = syn_q;
      dec_data_d  = dec_data_q;
      dec_err_d   = dec_err_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      out_valid_d = out_valid_q;
      corr_d      = corr_q;
      uncorr_d    = uncorr_q;
      drop_d      = drop_q;
      tout_d      = tout_q;

      // Bit assembly runs in every state so the next codeword can start early.
      if (bit_valid) begin
         sr_d  = {bit_in, sr_q[CW_W-1:1]};
         tmr_d = '0;
         if (bit_cnt_q == 4'(CW_W - 1)) begin
            bit_cnt_d = '0;
         end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end else if (bit_cnt_q != 4'd0) begin
         if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
            bit_cnt_d = '0;
            tmr_d     = '0;
            tout_d    = sat_inc(tout_q);
         end else begin
            tmr_d = tmr_q + 1'b1;
         end
      end

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         S_COLLECT: begin
            if (bit_valid && (bit_cnt_q == 4'(CW_W - 1))) begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            syn_d      = syn_comb;
            dec_data_d = data_comb;
            dec_err_d  = err_comb;
            state_d    = S_PUSH;
         end
         S_PUSH: begin
            if (!out_valid_q || out_ready) begin
               out_data_d  = dec_data_q;
               out_err_d   = dec_err_q;
               out_valid_d = 1'b1;
            end else begin
               drop_d = sat_inc(drop_q);
            end
            if (syn_q > SYN_MAX_CORR) begin
               uncorr_d = sat_inc(uncorr_q);
            end else if (syn_q != 4'd0) begin
               corr_d = sat_inc(corr_q);
            end
            state_d = S_COLLECT;
         end
         default: state_d = S_COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_COLLECT;
         bit_cnt_q   <= '0;
         sr_q        <= '0;
         tmr_q       <= '0;
         syn_q       <= '0;
         dec_data_q  <= '0;
         dec_err_q   <= ERR_NONE;
         out_data_q  <= '0;
         out_err_q   <= ERR_NONE;
         out_valid_q <= 1'b0;
         corr_q      <= '0;
         uncorr_q    <= '0;
         drop_q      <= '0;
         tout_q      <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         sr_q        <= sr_d;
         tmr_q       <= tmr_d;
         syn_q       <= syn_d;
         dec_data_q  <= dec_data_d;
         dec_err_q   <= dec_err_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
         out_valid_q <= out_valid_d;
         corr_q      <= corr_d;
         uncorr_q    <= uncorr_d;
         drop_q      <= drop_d;
         tout_q      <= tout_d;
      end
   end

   assign out_data    = out_data_q;
   assign out_err     = out_err_q;
   assign out_valid   = out_valid_q;
   assign corr_cnt    = corr_q;
   assign uncorr_cnt  = uncorr_q;
   assign drop_cnt    = drop_q;
   assign timeout_cnt = tout_q;
   assign busy        = (bit_cnt_q != 4'd0) || (state_q != S_COLLECT);

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// tb_hamming_rx_ctrl: directed scenarios plus a randomized codeword stream checked
// against a position-based Hamming model.
module tb_hamming_rx_ctrl;

   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             bit_in = 1'b0;
   logic             bit_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic [7:0]       out_data;
   logic [1:0]       out_err;
   logic             out_valid;
   logic [CNT_W-1:0] corr_cnt, uncorr_cnt, drop_cnt, timeout_cnt;
   logic             busy;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [9:0] got_q[$];

   hamming_rx_ctrl #(
      .TIMEOUT (16),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .out_data    (out_data),
      .out_err     (out_err),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .corr_cnt    (corr_cnt),
      .uncorr_cnt  (uncorr_cnt),
      .drop_cnt    (drop_cnt),
      .timeout_cnt (timeout_cnt),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Record every accepted transfer; inputs change just after posedge, so negedge is stable.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) got_q.push_back({out_err, out_data});
   end

   // Reference: syndrome is the XOR of the 1-based positions of all set bits.
   function automatic logic [9:0] model(input logic [11:0] cw);
      int         s;
      int         k;
      logic [11:0] c;
      logic [7:0] d;
      logic [1:0] e;
      s = 0;
      for (int i = 0; i < 12; i++) if (cw[i]) s = s ^ (i + 1);
      c = cw;
      if (s == 0) e = 2'b00;
      else if (s <= 12) begin
         c[s-1] = ~c[s-1];
         e = 2'b01;
      end else e = 2'b10;
      k = 0;
      d = 8'h00;
      for (int p = 1; p <= 12; p++) begin
         if ((p & (p - 1)) != 0) begin
            d[k] = c[p-1];
            k++;
         end
      end
      return {e, d};
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b);
      bit_in    = b;
      bit_valid = 1'b1;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
   endtask

   task automatic send_cw(input logic [11:0] cw, input int max_gap);
      for (int i = 0; i < 12; i++) begin
         send_bit(cw[i]);
         if (max_gap > 0 && i < 11) idle($urandom_range(0, max_gap));
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      bit_valid = 1'b0;
      idle(2);
      rst = 1'b0;
      got_q.delete();
   endtask

   task automatic wait_outputs(input int n, input int budget);
      int k;
      k = 0;
      while (got_q.size() < n && k < budget) begin
         idle(1);
         k++;
      end
      n_cmp++;
      if (got_q.size() < n) begin
         n_fail++;
         $display("FAIL wait_outputs: got %0d transfers, required %0d", got_q.size(), n);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({out_valid, out_data, out_err, busy} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b data=%h err=%b busy=%b, required all 0",
                  out_valid, out_data, out_err, busy);
      end
      n_cmp++;
      if ({corr_cnt, uncorr_cnt, drop_cnt, timeout_cnt} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_counters: %h %h %h %h, required 0",
                  corr_cnt, uncorr_cnt, drop_cnt, timeout_cnt);
      end
   endtask

   task automatic test_clean();
      do_reset();
      out_ready = 1'b1;
      send_cw(12'hF77, 0);
      wait_outputs(1, 20);
      n_cmp++;
      if (got_q[0] !== {2'b00, 8'hFF}) begin
         n_fail++;
         $display("FAIL clean_byte: got %h, required %h", got_q[0], {2'b00, 8'hFF});
      end
      n_cmp++;
      if ({corr_cnt, uncorr_cnt, drop_cnt, timeout_cnt} !== 64'h0) begin
         n_fail++;
         $display("FAIL clean_counters: %h %h %h %h, required 0",
                  corr_cnt, uncorr_cnt, drop_cnt, timeout_cnt);
      end
   endtask

   task automatic test_single_err();
      do_reset();
      out_ready = 1'b1;
      send_cw(12'hF57, 0);
      wait_outputs(1, 20);
      n_cmp++;
      if (got_q[0] !== {2'b01, 8'hFF}) begin
         n_fail++;
         $display("FAIL corr_byte: got %h, required %h", got_q[0], {2'b01, 8'hFF});
      end
      n_cmp++;
      if (corr_cnt !== 16'd1 || uncorr_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL corr_count: corr=%0d uncorr=%0d, required 1/0", corr_cnt, uncorr_cnt);
      end
   endtask

   task automatic test_uncorr();
      do_reset();
      out_ready = 1'b1;
      send_cw(12'h089, 0);
      wait_outputs(1, 20);
      n_cmp++;
      if (got_q[0] !== {2'b10, 8'h00}) begin
         n_fail++;
         $display("FAIL uncorr_byte: got %h, required %h", got_q[0], {2'b10, 8'h00});
      end
      n_cmp++;
      if (uncorr_cnt !== 16'd1 || corr_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL uncorr_count: uncorr=%0d corr=%0d, required 1/0", uncorr_cnt, corr_cnt);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      send_cw(12'h000, 0);
      send_cw(12'hF77, 0);
      send_cw(12'h000, 0);
      idle(4);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h00 || out_err !== 2'b00) begin
         n_fail++;
         $display("FAIL bp_held: valid=%b data=%h err=%b, required 1/00/00",
                  out_valid, out_data, out_err);
      end
      n_cmp++;
      if (drop_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL bp_drops: drop_cnt=%0d, required 2", drop_cnt);
      end
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || got_q.size() != 1) begin
         n_fail++;
         $display("FAIL bp_release: valid=%b transfers=%0d, required 0/1",
                  out_valid, got_q.size());
      end
   endtask

   task automatic test_timeout();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
      idle(16);
      n_cmp++;
      if (timeout_cnt !== 16'd1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_abort: timeout_cnt=%0d busy=%b, required 1/0", timeout_cnt, busy);
      end
      send_cw(12'hF77, 0);
      wait_outputs(1, 20);
      n_cmp++;
      if (got_q[0] !== {2'b00, 8'hFF} || timeout_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL timeout_next: got %h tcnt=%0d, required %h/1",
                  got_q[0], timeout_cnt, {2'b00, 8'hFF});
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 1'b1;
      send_cw(12'h000, 0);
      send_cw(12'hF77, 0);
      wait_outputs(2, 30);
      n_cmp++;
      if (got_q[0] !== 10'h000 || got_q[1] !== {2'b00, 8'hFF}) begin
         n_fail++;
         $display("FAIL b2b_bytes: got %h %h, required 000 0ff", got_q[0], got_q[1]);
      end
      n_cmp++;
      if (drop_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL b2b_drops: drop_cnt=%0d, required 0", drop_cnt);
      end
   endtask

   task automatic test_random();
      logic [9:0]  exp_q[$];
      logic [11:0] cw;
      logic [9:0]  m;
      int          n_corr;
      int          n_unc;
      do_reset();
      out_ready = 1'b1;
      n_corr = 0;
      n_unc  = 0;
      for (int t = 0; t < 40; t++) begin
         cw = 12'($urandom_range(0, 4095));
         m  = model(cw);
         exp_q.push_back(m);
         if (m[9:8] == 2'b01) n_corr++;
         if (m[9:8] == 2'b10) n_unc++;
         send_cw(cw, (t % 3));
      end
      wait_outputs(40, 50);
      for (int i = 0; i < 40; i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rand_byte[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (corr_cnt !== 16'(n_corr) || uncorr_cnt !== 16'(n_unc) || drop_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL rand_counters: corr=%0d uncorr=%0d drop=%0d, required %0d/%0d/0",
                  corr_cnt, uncorr_cnt, drop_cnt, n_corr, n_unc);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      out_ready = 1'b0;
      send_cw(12'h089, 0);
      idle(4);
      for (int i = 0; i < 6; i++) send_bit(1'b1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      n_cmp++;
      if ({out_valid, out_data, out_err, busy} !== 12'h000 ||
          {corr_cnt, uncorr_cnt, drop_cnt, timeout_cnt} !== 64'h0) begin
         n_fail++;
         $display("FAIL mid_reset: valid=%b data=%h err=%b busy=%b uncorr=%0d, required all 0",
                  out_valid, out_data, out_err, busy, uncorr_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_single_err();
      test_uncorr();
      test_backpressure();
      test_timeout();
      test_back_to_back();
      test_random();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
